// File: rtl/bn_pkg.sv
// Shared types and defaults for the batch-norm sequencer.
// Frame/channel index struct is shared with the datapath and buffers.
package bn_pkg;

  localparam int NUM_CH_D = 20;
  localparam int DW_D     = 32;
  localparam int AW_D     = 5;
  localparam int FW_D     = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [FW_D-1:0] frame;
    logic [AW_D-1:0] ch;
  } bn_idx_t;

endpackage

// File: rtl/bn_seq_retire.sv
// Retire side: credit counter, retire index, result write register, err.
// Runs alongside the issue FSM and reports progress back to it.
module bn_seq_retire
  import bn_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_D,
  parameter int DW      = DW_D,
  parameter int AW      = AW_D,
  parameter int FW      = FW_D,
  parameter int MAX_OUT = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_issue,
  input  logic          i_out_valid,
  input  logic [DW-1:0] i_out_data,
  input  logic [AW-1:0] i_out_ch,
  output logic [CW-1:0] o_credits,
  output logic [FW-1:0] o_ret_frame,
  output logic          o_wr_en,
  output logic [FW-1:0] o_wr_frame,
  output logic [AW-1:0] o_wr_ch,
  output logic [DW-1:0] o_wr_data,
  output logic          o_err
);

  logic [CW-1:0] r_credits;
  logic [FW-1:0] r_frame;
  logic [AW-1:0] r_ch;
  logic          r_wr_en;
  logic [FW-1:0] r_wr_frame;
  logic [AW-1:0] r_wr_ch;
  logic [DW-1:0] r_wr_data;
  logic          r_err;
  logic          w_ret;

  // A result with nothing in flight is stray and gets dropped.
  assign w_ret = i_out_valid && (r_credits != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits  <= '0;
      r_frame    <= '0;
      r_ch       <= '0;
      r_wr_en    <= 1'b0;
      r_wr_frame <= '0;
      r_wr_ch    <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= w_ret;
      if (w_ret) begin
        r_wr_frame <= r_frame;
        r_wr_ch    <= r_ch;
        r_wr_data  <= i_out_data;
        if (r_ch == AW'(NUM_CH - 1)) begin
          r_ch    <= '0;
          r_frame <= r_frame + FW'(1);
        end else begin
          r_ch <= r_ch + AW'(1);
        end
      end
      if (i_clr) begin
        r_frame <= '0;
        r_ch    <= '0;
        r_err   <= 1'b0;
      end else if (i_out_valid && (!w_ret || i_out_ch != r_ch)) begin
        r_err <= 1'b1;
      end
      unique case ({i_issue, w_ret})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign o_credits   = r_credits;
  assign o_ret_frame = r_frame;
  assign o_wr_en     = r_wr_en;
  assign o_wr_frame  = r_wr_frame;
  assign o_wr_ch     = r_wr_ch;
  assign o_wr_data   = r_wr_data;
  assign o_err       = r_err;

endmodule

// File: rtl/bn_sequencer.sv
// Sequences activation frames through the BN datapath into the result
// buffer; issue FSM and issue index live here, retire side is a submodule.
module bn_sequencer
  import bn_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_D,
  parameter int DW      = DW_D,
  parameter int AW      = AW_D,
  parameter int FW      = FW_D,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [FW-1:0] num_frames,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          act_rd_en,
  output logic [FW-1:0] act_rd_frame,
  output logic [AW-1:0] act_rd_ch,
  input  logic [DW-1:0] act_rd_data,
  output logic          bn_in_valid,
  input  logic          bn_in_ready,
  output logic [DW-1:0] bn_in_data,
  output logic [AW-1:0] bn_in_ch,
  input  logic          bn_out_valid,
  input  logic [DW-1:0] bn_out_data,
  input  logic [AW-1:0] bn_out_ch,
  output logic          res_wr_en,
  output logic [FW-1:0] res_wr_frame,
  output logic [AW-1:0] res_wr_ch,
  output logic [DW-1:0] res_wr_data
);

  localparam int CW = $clog2(MAX_OUT + 1);

  state_t        r_state;
  logic [FW-1:0] r_nf;
  logic [FW-1:0] r_if;
  logic [AW-1:0] r_ic;
  logic [DW-1:0] r_hold;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_credits;
  logic [FW-1:0] w_ret_frame;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_clr;
  logic          w_last_ch;
  logic          w_last;

  assign w_credit_ok = w_credits < CW'(MAX_OUT);
  assign w_issue     = (r_state == S_ISSUE) && bn_in_ready;
  assign w_clr       = (r_state == S_IDLE) && start;
  assign w_last_ch   = r_ic == AW'(NUM_CH - 1);
  assign w_last      = w_last_ch && (r_if == r_nf - FW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_nf    <= '0;
      r_if    <= '0;
      r_ic    <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_nf   <= num_frames;
            r_if   <= '0;
            r_ic   <= '0;
            r_busy <= 1'b1;
            if (num_frames == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_credit_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_hold  <= act_rd_data;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bn_in_ready) begin
            if (w_last_ch) begin
              r_ic <= '0;
              r_if <= r_if + FW'(1);
            end else begin
              r_ic <= r_ic + AW'(1);
            end
            r_state <= w_last ? S_DRAIN : S_FETCH;
          end
        end
        S_DRAIN: begin
          // Retire index wraps to (num_frames, 0) once all are written.
          if (w_ret_frame == r_nf) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign act_rd_en    = (r_state == S_FETCH) && w_credit_ok;
  assign act_rd_frame = r_if;
  assign act_rd_ch    = r_ic;
  assign bn_in_valid  = (r_state == S_ISSUE);
  assign bn_in_data   = r_hold;
  assign bn_in_ch     = r_ic;

  bn_seq_retire #(
    .NUM_CH  (NUM_CH),
    .DW      (DW),
    .AW      (AW),
    .FW      (FW),
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_retire (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_issue     (w_issue),
    .i_out_valid (bn_out_valid),
    .i_out_data  (bn_out_data),
    .i_out_ch    (bn_out_ch),
    .o_credits   (w_credits),
    .o_ret_frame (w_ret_frame),
    .o_wr_en     (res_wr_en),
    .o_wr_frame  (res_wr_frame),
    .o_wr_ch     (res_wr_ch),
    .o_wr_data   (res_wr_data),
    .o_err       (err)
  );

endmodule

// File: tb/tb_bn_sequencer.sv
// Bench for bn_sequencer: SRAM and BN datapath models plus a write
// scoreboard; expected writes queued as the datapath model emits results.
module tb_bn_sequencer;

  localparam int NCH = 20;
  localparam int MO  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  num_frames;
  logic        busy, done, err;
  logic        act_rd_en;
  logic [5:0]  act_rd_frame;
  logic [4:0]  act_rd_ch;
  logic [31:0] act_rd_data;
  logic        bn_in_valid, bn_in_ready;
  logic [31:0] bn_in_data;
  logic [4:0]  bn_in_ch;
  logic        bn_out_valid;
  logic [31:0] bn_out_data;
  logic [4:0]  bn_out_ch;
  logic        res_wr_en;
  logic [5:0]  res_wr_frame;
  logic [4:0]  res_wr_ch;
  logic [31:0] res_wr_data;

  bn_sequencer #(
    .NUM_CH (NCH), .DW (32), .AW (5), .FW (6), .MAX_OUT (MO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start),
    .num_frames (num_frames), .busy (busy), .done (done), .err (err),
    .act_rd_en (act_rd_en), .act_rd_frame (act_rd_frame),
    .act_rd_ch (act_rd_ch), .act_rd_data (act_rd_data),
    .bn_in_valid (bn_in_valid), .bn_in_ready (bn_in_ready),
    .bn_in_data (bn_in_data), .bn_in_ch (bn_in_ch),
    .bn_out_valid (bn_out_valid), .bn_out_data (bn_out_data),
    .bn_out_ch (bn_out_ch), .res_wr_en (res_wr_en),
    .res_wr_frame (res_wr_frame), .res_wr_ch (res_wr_ch),
    .res_wr_data (res_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  ch;
    int          due;
  } dp_t;

  typedef struct {
    logic [5:0]  f;
    logic [4:0]  ch;
    logic [31:0] d;
  } wr_t;

  dp_t dpq[$];
  wr_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc, lat, stall_cnt, outst;
  int n_rd, n_wr, n_hs, n_out, n_done, done_cyc, last_out, hs_first;
  int if_f, if_c, rf, rc, rd_f, rd_c, last_wr_f, last_wr_c;
  bit stall_en, corrupt, rst_trig, rst_hit, rd_pend, inject;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem(int f, int c);
    return {8'hC5, f[7:0], c[7:0], 8'h3C};
  endfunction

  function automatic logic [31:0] bnf(logic [31:0] d);
    return {d[15:0], d[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic tick();
    wr_t e;
    dp_t p;
    @(negedge clk);
    cyc++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (res_wr_en) begin
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(res_wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_frame", 32'(res_wr_frame), 32'(e.f));
        check("wr_ch", 32'(res_wr_ch), 32'(e.ch));
        check("wr_data", res_wr_data, e.d);
        n_wr++;
        last_wr_f = int'(res_wr_frame);
        last_wr_c = int'(res_wr_ch);
      end
    end
    if (act_rd_en) begin
      n_rd++;
      check("rd_credit", 32'(outst < MO), 32'd1);
      check("rd_idx", 32'({act_rd_frame, act_rd_ch}),
            32'({if_f[5:0], if_c[4:0]}));
      if (rst_trig && act_rd_frame == 6'd0 && act_rd_ch == 5'd10)
        rst_hit = 1'b1;
    end
    act_rd_data = rd_pend ? mem(rd_f, rd_c) : 32'hDEAD_BEEF;
    rd_pend = act_rd_en;
    rd_f = int'(act_rd_frame);
    rd_c = int'(act_rd_ch);
    bn_out_valid = 1'b0;
    bn_out_data = '0;
    bn_out_ch = '0;
    if (inject) begin
      bn_out_valid = 1'b1;
      bn_out_data = 32'h1111_2222;
    end else if (dpq.size() != 0 && dpq[0].due <= cyc) begin
      p = dpq.pop_front();
      if (n_out == 0) hs_first = n_hs;
      bn_out_valid = 1'b1;
      bn_out_data = bnf(p.d);
      bn_out_ch = (corrupt && n_out == 3) ? 5'd5 : p.ch;
      sb.push_back('{f: rf[5:0], ch: rc[4:0], d: bnf(p.d)});
      if (rc == NCH - 1) begin
        rc = 0;
        rf++;
      end else begin
        rc++;
      end
      n_out++;
      outst--;
      last_out = cyc;
    end
    bn_in_ready = 1'b1;
    if (stall_en && bn_in_valid && n_hs == 6 && stall_cnt < 5) begin
      bn_in_ready = 1'b0;
      stall_cnt++;
      check("stall_data", bn_in_data, mem(if_f, if_c));
    end
    if (bn_in_valid && bn_in_ready) begin
      check("in_data", bn_in_data, mem(if_f, if_c));
      check("in_ch", 32'(bn_in_ch), 32'(if_c));
      check("in_credit", 32'(outst < MO), 32'd1);
      dpq.push_back('{d: bn_in_data, ch: bn_in_ch, due: cyc + lat});
      n_hs++;
      outst++;
      if (if_c == NCH - 1) begin
        if_c = 0;
        if_f++;
      end else begin
        if_c++;
      end
    end
  endtask

  task automatic clear_model();
    dpq.delete();
    sb.delete();
    n_rd = 0; n_wr = 0; n_hs = 0; n_out = 0; n_done = 0;
    done_cyc = -1; last_out = -1; hs_first = -1; outst = 0;
    if_f = 0; if_c = 0; rf = 0; rc = 0; stall_cnt = 0;
    rd_pend = 1'b0; rst_hit = 1'b0; inject = 1'b0;
    last_wr_f = -1; last_wr_c = -1;
  endtask

  task automatic run(int nf, int l, bit st, bit cor, bit rs);
    clear_model();
    lat = l; stall_en = st; corrupt = cor; rst_trig = rs;
    num_frames = nf[5:0];
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    check("err_clear", 32'(err), 32'd0);
    if (nf != 0) begin
      check("rd_c1", 32'(act_rd_en), 32'd1);
      check("rd_c1_idx", 32'({act_rd_frame, act_rd_ch}), 32'd0);
    end
    while (n_done == 0 && !rst_hit && cyc < 5000) tick();
    if (rs) begin
      check("rst_reached", 32'(rst_hit), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_ctl", 32'({busy, done, err, act_rd_en, bn_in_valid,
            res_wr_en}), 32'd0);
      check("rst_idx", 32'({act_rd_frame, act_rd_ch, bn_in_ch,
            res_wr_frame, res_wr_ch}), 32'd0);
      check("rst_in_data", bn_in_data, 32'd0);
      check("rst_wr_data", res_wr_data, 32'd0);
      clear_model();
      rst_trig = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
    end else begin
      check("done_seen", 32'(n_done != 0), 32'd1);
      if (nf == 0) check("done_c1", 32'(done_cyc), 32'd1);
      else check("done_lat", 32'(done_cyc), 32'(last_out + 2));
      tick();
      check("busy_low", 32'(busy), 32'd0);
      check("done_once", 32'(n_done), 32'd1);
      check("n_rd", 32'(n_rd), 32'(nf * NCH));
      check("n_wr", 32'(n_wr), 32'(nf * NCH));
      check("sb_empty", 32'(sb.size()), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_frames = '0;
    act_rd_data = '0; bn_in_ready = 1'b0;
    bn_out_valid = 1'b0; bn_out_data = '0; bn_out_ch = '0;
    stall_en = 1'b0; corrupt = 1'b0; rst_trig = 1'b0; lat = 3;
    cyc = 0;
    clear_model();
    tick();
    tick();
    check("reset_ctl", 32'({busy, done, err, act_rd_en, bn_in_valid,
          res_wr_en}), 32'd0);
    check("reset_wr_data", res_wr_data, 32'd0);
    rst_n = 1'b1;
    tick();

    run(1, 3, 1'b0, 1'b0, 1'b0);
    check("single_err", 32'(err), 32'd0);

    run(2, 3, 1'b1, 1'b0, 1'b0);
    check("bp_stalls", 32'(stall_cnt), 32'd5);
    check("bp_last_wr", 32'({last_wr_f[5:0], last_wr_c[4:0]}),
          32'({6'd1, 5'd19}));

    run(1, 30, 1'b0, 1'b0, 1'b0);
    check("credit_hs_first", 32'(hs_first), 32'(MO));

    run(0, 3, 1'b0, 1'b0, 1'b0);
    check("zero_err", 32'(err), 32'd0);

    run(1, 3, 1'b0, 1'b1, 1'b0);
    check("ch_err", 32'(err), 32'd1);

    run(1, 3, 1'b0, 1'b0, 1'b0);
    clear_model();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    tick();
    check("idle_err", 32'(err), 32'd1);
    check("idle_nowr", 32'(n_wr), 32'd0);

    run(2, 3, 1'b0, 1'b0, 1'b1);
    run(1, 3, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bn_sequencer.md
# bn_sequencer

Controller that sequences feature frames from the activation buffer through the batch-normalization datapath and writes normalized results to the result buffer. Sits between the activation SRAM read port, the BN datapath (valid/ready on input, valid-only on output) and the result SRAM write port. Processes `num_frames` frames of `NUM_CH` channels each: channel is the inner index, frame the outer. Bounds in-flight elements with a credit counter and raises `done` when the last result is written.

## Interface
- `NUM_CH`, default 20: channels per frame.
- `DW`, default 32: data width (1.7.24 fixed point, passed through untouched).
- `AW`, default 5: channel index width, at least clog2(`NUM_CH`).
- `FW`, default 6: frame index width.
- `MAX_OUT`, default 4: maximum elements issued to the datapath but not yet retired.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; honoured only in IDLE, ignored otherwise.
- `num_frames` in FW: frame count, latched on accepted `start`.
- `busy` out 1: high from the cycle after `start` until the cycle after `done`.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: sticky error flag; cleared on accepted `start`.
- `act_rd_en` out 1 / `act_rd_frame` out FW / `act_rd_ch` out AW: activation read request.
- `act_rd_data` in DW: read data, valid exactly one cycle after `act_rd_en`.
- `bn_in_valid` out 1 / `bn_in_ready` in 1 / `bn_in_data` out DW / `bn_in_ch` out AW: datapath input.
- `bn_out_valid` in 1 / `bn_out_data` in DW / `bn_out_ch` in AW: datapath result.
- `res_wr_en` out 1 / `res_wr_frame` out FW / `res_wr_ch` out AW / `res_wr_data` out DW: result write.

## Operation
- **Reset values:** all outputs are 0; state is IDLE; counters and credits are 0.
- **Issue FSM states:** IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE.
- **IDLE → FETCH** on `start` with `num_frames` ≠ 0.
- **IDLE → DONE** on `start` with `num_frames` = 0. This gives a single `done` pulse with no reads or writes.
- **FETCH:**
  - Waits while outstanding = `MAX_OUT`; `act_rd_en` stays low during the wait.
  - Otherwise drives `act_rd_en`=1 at the current issue (frame, ch), then goes to WAIT.
- **WAIT:** captures `act_rd_data` into a holding register, then goes to ISSUE.
- **ISSUE:**
  - Holds `bn_in_valid`=1 with a stable `bn_in_data` and `bn_in_ch` until `bn_in_ready`.
  - On handshake: outstanding +1 and issue index advances.
  - Channel advance: ch `NUM_CH`-1 wraps to 0 with frame +1.
  - After the last element, goes to DRAIN; otherwise goes to FETCH.
- **Retire side** runs concurrently with the issue FSM:
  - Each `bn_out_valid` decrements outstanding and registers a write.
  - The write goes to the retire (frame, ch) counter, not the returned channel.
  - Retire counter wraps the same way as the issue counter.
- **Simultaneous issue handshake and retire:** outstanding is unchanged.
- **DRAIN → DONE** when the retired count equals `num_frames`×`NUM_CH`.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`err` sets on either condition:**
  - `bn_out_ch` ≠ expected retire channel. The result is still written.
  - `bn_out_valid` arrives while outstanding = 0, including in IDLE. That result is dropped and counters do not change.
- **Reset mid-operation:** state returns to IDLE and in-flight results are discarded. The datapath shares `rst_n`.

## Timing
- Accepted `start` at cycle 0: `busy` rises in cycle 1 (FETCH), with `act_rd_en` in cycle 1.
- Read data is captured in cycle 2 (WAIT). `bn_in_valid` is asserted in cycle 3.
- Peak issue rate: one element per 3 cycles.
- `bn_out_valid` in cycle r gives `res_wr_en` in cycle r+1, with data, frame and ch registered.
- Final write in cycle r+1: `done` in cycle r+2, `busy` low in cycle r+3.
- `bn_in_valid` never deasserts before `bn_in_ready`.
- `act_rd_en` is never asserted outside FETCH.

## Structure
- Shared package `bn_pkg` holds:
  - the FSM state encoding;
  - `NUM_CH`, `DW`, `AW`, `FW` defaults;
  - a frame/channel index struct, reused by the BN datapath and the buffers.
- One sub-module, `bn_seq_retire`, holds the retire counter, credit counter, write register and `err` logic.
- The top holds the issue FSM and the issue counter.

## Test plan
- **Single frame:** `num_frames`=1, `bn_in_ready`=1, datapath latency 3.
  - Expect 20 reads and 20 writes, ch 0..19 in order, data equal to the datapath output.
  - `done` exactly 2 cycles after the last `bn_out_valid`.
- **Backpressure:** `num_frames`=2, `bn_in_ready` low for 5 cycles on the 7th element.
  - `bn_in_data` is stable throughout.
  - The write at frame 1, ch 19 is the 40th write; `done` pulses once.
- **Credit stall:** datapath latency 30, `MAX_OUT`=4.
  - No more than 4 `bn_in_valid` handshakes before the first retire.
  - `act_rd_en` stays low while outstanding = 4.
- **Zero frames:** `num_frames`=0 → `done` in cycle 1; no reads or writes; `err`=0.
- **Errors:**
  - `bn_out_ch`=5 returned when 3 is expected → `err`=1 and the write still goes to ch 3.
  - `bn_out_valid` in IDLE → `err`=1 and no write.
  - Next `start` clears `err`.
- **Reset mid-run:** `rst_n` low during frame 0, ch 10.
  - All outputs are 0 and `busy`=0.
  - A new `start` restarts at frame 0, ch 0.
